// File: rtl/sandbox_pkg.sv
// Shared definitions for the sandbox host-command router: FSM state
// encodings, error codes and control-byte field helpers.
package sandbox_pkg;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_WAIT = 1'b1
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_BUSY  = 2'd2
  } tx_state_e;

  localparam logic [3:0] ERR_BAD_CH  = 4'hE;
  localparam logic [3:0] ERR_TIMEOUT = 4'hF;

  localparam int CTRL_CH_LSB  = 4;
  localparam int CTRL_OP_LSB  = 0;
  localparam int CTRL_FIELD_W = 4;

  function automatic logic [3:0] ctrl_channel(input logic [7:0] ctrl);
    return ctrl[CTRL_CH_LSB +: CTRL_FIELD_W];
  endfunction

  function automatic logic [3:0] ctrl_opcode(input logic [7:0] ctrl);
    return ctrl[CTRL_OP_LSB +: CTRL_FIELD_W];
  endfunction

endpackage

// File: rtl/sandbox_rr_arbiter.sv
// Combinational round-robin search: returns the first requesting channel
// at or after the pointer, wrapping around. The pointer lives in the router.
module sandbox_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int PW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [NUM_CH-1:0] grant,
  output logic              valid
);

  // Scan channels starting at ptr and grant the first requester found
  always_comb begin : search
    int cand;
    cand  = 0;
    grant = '0;
    valid = 1'b0;
    for (int off = 0; off < NUM_CH; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (!valid && cand < NUM_CH && req[cand]) begin
        grant[cand] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sandbox_router.sv
// Multi-channel host-command router between the UART I/O block and up to
// 16 sandbox DUT channels. Commands are decoded and strobed to one channel;
// channel responses are arbitrated round-robin into the UART transmitter.
// Optional response watchdog: define SANDBOX_ROUTER_WATCHDOG_EN.
module sandbox_router
  import sandbox_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int WIDTH          = 4,
  parameter int TIMEOUT_CYCLES = 12000000
) (
  input  logic                       masterClock,
  input  logic                       reset,
  input  logic                       dataReceived,
  input  logic [7:0]                 control,
  input  logic [WIDTH*8-1:0]         inputData,
  input  logic                       transmitting,
  output logic                       clearDR,
  output logic                       transmit,
  output logic [7:0]                 status,
  output logic [WIDTH*8-1:0]         outputData,
  output logic [NUM_CH-1:0]          chValid,
  output logic [3:0]                 chControl,
  output logic [WIDTH*8-1:0]         chData,
  input  logic [NUM_CH-1:0]          chTxReq,
  input  logic [NUM_CH*4-1:0]        chStatus,
  input  logic [NUM_CH*WIDTH*8-1:0]  chTxData,
  output logic [NUM_CH-1:0]          chTxAck
);

  localparam int DW = WIDTH * 8;
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  rx_state_e         rx_state_q, rx_state_d;
  logic [3:0]        ch_control_q, ch_control_d;
  logic [DW-1:0]     ch_data_q, ch_data_d;
  logic              clear_dr_q, clear_dr_d;
  logic [NUM_CH-1:0] ch_valid_q, ch_valid_d;

  tx_state_e         tx_state_q, tx_state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [7:0]        status_q, status_d;
  logic [DW-1:0]     output_data_q, output_data_d;
  logic              transmit_q, transmit_d;
  logic [NUM_CH-1:0] ch_tx_ack_q, ch_tx_ack_d;

  logic              err_pending_q, err_pending_d;
  logic [3:0]        err_ch_q, err_ch_d;
  logic [3:0]        err_code_q, err_code_d;

  logic [3:0]        rx_ch;
  logic              rx_err_set;
  logic              rx_dispatch;
  logic              tx_err_take;
  logic              wd_err_set;
  logic [3:0]        wd_err_ch;

  logic [NUM_CH-1:0] arb_grant;
  logic              arb_valid;
  logic [3:0]        grant_idx;
  logic [3:0]        sel_status;
  logic [DW-1:0]     sel_data;

  sandbox_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .PW     (PW)
  ) u_arbiter (
    .req   (chTxReq),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  assign rx_ch = ctrl_channel(control);

  // RX path: latch a received word, strobe its channel once, then wait for the UART to drop dataReceived
  always_comb begin
    rx_state_d   = rx_state_q;
    ch_control_d = ch_control_q;
    ch_data_d    = ch_data_q;
    clear_dr_d   = 1'b0;
    ch_valid_d   = '0;
    rx_err_set   = 1'b0;
    rx_dispatch  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (dataReceived) begin
          ch_control_d = ctrl_opcode(control);
          ch_data_d    = inputData;
          clear_dr_d   = 1'b1;
          if (int'(rx_ch) < NUM_CH) begin
            ch_valid_d  = NUM_CH'(1) << rx_ch;
            rx_dispatch = 1'b1;
          end else begin
            rx_err_set = 1'b1;
          end
          rx_state_d = RX_WAIT;
        end
      end
      RX_WAIT: begin
        if (!dataReceived) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Convert the one-hot grant into an index and pick that channel's status and data
  always_comb begin
    grant_idx  = '0;
    sel_status = '0;
    sel_data   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_grant[i]) begin
        grant_idx  = 4'(i);
        sel_status = chStatus[4*i +: 4];
        sel_data   = chTxData[DW*i +: DW];
      end
    end
  end

  // TX path: pending error beats channel requests; one response per UART transmission
  always_comb begin
    tx_state_d    = tx_state_q;
    ptr_d         = ptr_q;
    status_d      = status_q;
    output_data_d = output_data_q;
    transmit_d    = 1'b0;
    ch_tx_ack_d   = '0;
    tx_err_take   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!transmitting) begin
          if (err_pending_q) begin
            status_d      = {err_ch_q, err_code_q};
            output_data_d = '0;
            transmit_d    = 1'b1;
            tx_err_take   = 1'b1;
            tx_state_d    = TX_START;
          end else if (arb_valid) begin
            status_d      = {grant_idx, sel_status};
            output_data_d = sel_data;
            ch_tx_ack_d   = arb_grant;
            transmit_d    = 1'b1;
            ptr_d         = (int'(grant_idx) >= NUM_CH - 1) ? '0 : PW'(int'(grant_idx) + 1);
            tx_state_d    = TX_START;
          end
        end
      end
      TX_START: begin
        if (transmitting) tx_state_d = TX_BUSY;
      end
      TX_BUSY: begin
        if (!transmitting) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

`ifdef SANDBOX_ROUTER_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic            wd_active_q, wd_active_d;
  logic [3:0]      wd_ch_q, wd_ch_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_acked;

  // Watchdog: time the last dispatched channel until it is acknowledged or the limit is hit
  always_comb begin
    wd_active_d = wd_active_q;
    wd_ch_d     = wd_ch_q;
    wd_cnt_d    = wd_cnt_q;
    wd_err_set  = 1'b0;
    wd_acked    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_tx_ack_q[i] && int'(wd_ch_q) == i) wd_acked = 1'b1;
    end
    if (wd_active_q) begin
      if (wd_acked) begin
        wd_active_d = 1'b0;
        wd_cnt_d    = '0;
      end else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
        wd_err_set  = 1'b1;
        wd_active_d = 1'b0;
      end else begin
        wd_cnt_d = wd_cnt_q + 1'b1;
      end
    end
    if (rx_dispatch) begin
      wd_active_d = 1'b1;
      wd_ch_d     = rx_ch;
      wd_cnt_d    = '0;
    end
  end

  assign wd_err_ch = wd_ch_q;

  // Watchdog tracker registers
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      wd_active_q <= 1'b0;
      wd_ch_q     <= '0;
      wd_cnt_q    <= '0;
    end else begin
      wd_active_q <= wd_active_d;
      wd_ch_q     <= wd_ch_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end
`else
  assign wd_err_set = 1'b0;
  assign wd_err_ch  = '0;
`endif

  // Single-entry error slot: a newer error overwrites an older unsent one
  always_comb begin
    err_pending_d = err_pending_q;
    err_ch_d      = err_ch_q;
    err_code_d    = err_code_q;
    if (tx_err_take) err_pending_d = 1'b0;
    if (wd_err_set) begin
      err_pending_d = 1'b1;
      err_ch_d      = wd_err_ch;
      err_code_d    = ERR_TIMEOUT;
    end
    if (rx_err_set) begin
      err_pending_d = 1'b1;
      err_ch_d      = rx_ch;
      err_code_d    = ERR_BAD_CH;
    end
  end

  // State and output registers for both paths
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      rx_state_q    <= RX_IDLE;
      ch_control_q  <= '0;
      ch_data_q     <= '0;
      clear_dr_q    <= 1'b0;
      ch_valid_q    <= '0;
      tx_state_q    <= TX_IDLE;
      ptr_q         <= '0;
      status_q      <= '0;
      output_data_q <= '0;
      transmit_q    <= 1'b0;
      ch_tx_ack_q   <= '0;
      err_pending_q <= 1'b0;
      err_ch_q      <= '0;
      err_code_q    <= '0;
    end else begin
      rx_state_q    <= rx_state_d;
      ch_control_q  <= ch_control_d;
      ch_data_q     <= ch_data_d;
      clear_dr_q    <= clear_dr_d;
      ch_valid_q    <= ch_valid_d;
      tx_state_q    <= tx_state_d;
      ptr_q         <= ptr_d;
      status_q      <= status_d;
      output_data_q <= output_data_d;
      transmit_q    <= transmit_d;
      ch_tx_ack_q   <= ch_tx_ack_d;
      err_pending_q <= err_pending_d;
      err_ch_q      <= err_ch_d;
      err_code_q    <= err_code_d;
    end
  end

  assign clearDR    = clear_dr_q;
  assign transmit   = transmit_q;
  assign status     = status_q;
  assign outputData = output_data_q;
  assign chValid    = ch_valid_q;
  assign chControl  = ch_control_q;
  assign chData     = ch_data_q;
  assign chTxAck    = ch_tx_ack_q;

endmodule

// File: tb/tb_sandbox_router.sv
// Self-checking bench for sandbox_router: directed command/response steps
// followed by a randomized phase, all checked against a small reference
// model of the routing rules (error slot, round-robin pointer).
module tb_sandbox_router;

  localparam int NUM_CH  = 4;
  localparam int WIDTH   = 4;
  localparam int DW      = WIDTH * 8;
  localparam int TIMEOUT = 100;

  logic                     masterClock = 1'b0;
  logic                     reset;
  logic                     dataReceived;
  logic [7:0]               control;
  logic [DW-1:0]            inputData;
  logic                     transmitting;
  logic                     clearDR;
  logic                     transmit;
  logic [7:0]               status;
  logic [DW-1:0]            outputData;
  logic [NUM_CH-1:0]        chValid;
  logic [3:0]               chControl;
  logic [DW-1:0]            chData;
  logic [NUM_CH-1:0]        chTxReq;
  logic [NUM_CH*4-1:0]      chStatus;
  logic [NUM_CH*DW-1:0]     chTxData;
  logic [NUM_CH-1:0]        chTxAck;

  int         total = 0;
  int         bad   = 0;
  int         mPtr  = 0;
  bit         mErrValid = 1'b0;
  logic [7:0] mErrStatus = '0;

  sandbox_router #(
    .NUM_CH         (NUM_CH),
    .WIDTH          (WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .masterClock  (masterClock),
    .reset        (reset),
    .dataReceived (dataReceived),
    .control      (control),
    .inputData    (inputData),
    .transmitting (transmitting),
    .clearDR      (clearDR),
    .transmit     (transmit),
    .status       (status),
    .outputData   (outputData),
    .chValid      (chValid),
    .chControl    (chControl),
    .chData       (chData),
    .chTxReq      (chTxReq),
    .chStatus     (chStatus),
    .chTxData     (chTxData),
    .chTxAck      (chTxAck)
  );

  always #5 masterClock = ~masterClock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issue one host command and check the dispatch one cycle later
  task automatic applyStimulus(input logic [7:0] ctrl, input logic [DW-1:0] data, input int hold);
    int                idx;
    logic [NUM_CH-1:0] expValid;
    @(negedge masterClock);
    dataReceived = 1'b1;
    control      = ctrl;
    inputData    = data;
    @(negedge masterClock);
    idx = int'(ctrl[7:4]);
    expValid = '0;
    if (idx < NUM_CH) expValid[idx] = 1'b1;
    else begin
      mErrValid  = 1'b1;
      mErrStatus = {ctrl[7:4], 4'hE};
    end
    checkOutput("cmd_chValid", chValid, expValid);
    checkOutput("cmd_clearDR", clearDR, 1);
    checkOutput("cmd_chControl", chControl, ctrl[3:0]);
    checkOutput("cmd_chData", chData, data);
    for (int i = 0; i < hold; i++) begin
      @(negedge masterClock);
      checkOutput("hold_chValid", chValid, 0);
      checkOutput("hold_clearDR", clearDR, 0);
    end
    dataReceived = 1'b0;
  endtask

  // Wait for the next response and compare it with the model's choice
  task automatic grabGrant(input int bound);
    int                waited;
    int                g;
    int                c;
    bit                isErr;
    logic [7:0]        expStatus;
    logic [DW-1:0]     expData;
    logic [NUM_CH-1:0] expAck;
    waited = 0;
    do begin
      @(negedge masterClock);
      waited++;
    end while (transmit !== 1'b1 && waited < bound);
    if (transmit !== 1'b1) begin
      checkOutput("grant_wait", {63'd0, transmit}, 64'd1);
      return;
    end
    g = -1;
    expAck = '0;
    if (mErrValid) begin
      isErr     = 1'b1;
      expStatus = mErrStatus;
      expData   = '0;
      mErrValid = 1'b0;
    end else begin
      isErr = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        c = (mPtr + k) % NUM_CH;
        if (g < 0 && chTxReq[c]) g = c;
      end
      if (g < 0) g = 0;
      expStatus = {4'(g), chStatus[g*4 +: 4]};
      expData   = chTxData[g*DW +: DW];
      expAck[g] = 1'b1;
      mPtr      = (g + 1) % NUM_CH;
    end
    checkOutput("resp_status", status, expStatus);
    checkOutput("resp_outputData", outputData, expData);
    checkOutput("resp_chTxAck", chTxAck, expAck);
    if (!isErr) chTxReq[g] = 1'b0;
    @(negedge masterClock);
    checkOutput("transmit_pulse", transmit, 0);
    checkOutput("ack_pulse", chTxAck, 0);
  endtask

  task automatic finishTx(input int cycles);
    transmitting = 1'b1;
    repeat (cycles) @(negedge masterClock);
    transmitting = 1'b0;
  endtask

  task automatic serve(input int cycles);
    grabGrant(60);
    finishTx(cycles);
  endtask

  initial begin
    int                pulses;
    int                guard;
    logic [7:0]        ctrl;
    logic [NUM_CH-1:0] reqv;

    reset        = 1'b0;
    dataReceived = 1'b0;
    control      = '0;
    inputData    = '0;
    transmitting = 1'b0;
    chTxReq      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      chStatus[i*4 +: 4]   = 4'(i + 5);
      chTxData[i*DW +: DW] = 32'h1000_0000 * (i + 1) + 32'h55;
    end

    // Reset values
    repeat (2) @(negedge masterClock);
    checkOutput("rst_clearDR", clearDR, 0);
    checkOutput("rst_transmit", transmit, 0);
    checkOutput("rst_status", status, 0);
    checkOutput("rst_outputData", outputData, 0);
    checkOutput("rst_chValid", chValid, 0);
    checkOutput("rst_chTxAck", chTxAck, 0);
    reset = 1'b1;

    $display("[TB] command dispatch with dataReceived held");
    applyStimulus(8'h23, 32'hDEADBEEF, 5);

    $display("[TB] round-robin over all channels");
    chTxReq = 4'b1111;
    repeat (4) serve(2);
    chTxReq = 4'b0010;
    serve(3);

    $display("[TB] bad channel index");
    applyStimulus(8'h73, 32'h12345678, 0);
    serve(1);

    $display("[TB] error and request together");
    applyStimulus(8'hA1, 32'h0BADF00D, 0);
    chTxReq[2] = 1'b1;
    serve(2);
    serve(2);

    $display("[TB] newer error overwrites older one");
    chTxReq = 4'b0001;
    grabGrant(60);
    transmitting = 1'b1;
    applyStimulus(8'h5C, 32'h1, 0);
    applyStimulus(8'h9D, 32'h2, 0);
    finishTx(1);
    serve(2);
    pulses = 0;
    repeat (10) begin
      @(negedge masterClock);
      if (transmit === 1'b1) pulses++;
    end
    checkOutput("single_err_slot", pulses, 0);

    $display("[TB] reset during transmission");
    chTxReq = 4'b0100;
    grabGrant(60);
    transmitting = 1'b1;
    @(negedge masterClock);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_status", status, 0);
    checkOutput("async_outputData", outputData, 0);
    checkOutput("async_chControl", chControl, 0);
    checkOutput("async_chData", chData, 0);
    checkOutput("async_transmit", transmit, 0);
    @(negedge masterClock);
    transmitting = 1'b0;
    reset        = 1'b1;
    mPtr         = 0;
    mErrValid    = 1'b0;
    chTxReq      = 4'b1001;
    serve(1);
    serve(1);

    $display("[TB] randomized commands and responses");
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        chStatus[i*4 +: 4]   = 4'($urandom);
        chTxData[i*DW +: DW] = $urandom;
      end
      ctrl = {4'($urandom_range(0, 7)), 4'($urandom)};
      applyStimulus(ctrl, $urandom, 0);
      reqv = NUM_CH'($urandom);
      if (int'(ctrl[7:4]) < NUM_CH) reqv[int'(ctrl[7:4])] = 1'b1;
      chTxReq = reqv;
      guard = 0;
      while ((chTxReq != '0 || mErrValid) && guard < 8) begin
        serve(int'($urandom_range(1, 4)));
        guard++;
      end
    end

    $display("[TB] unanswered dispatch");
    applyStimulus(8'h1A, 32'hCAFEF00D, 0);
`ifdef SANDBOX_ROUTER_WATCHDOG_EN
    mErrValid  = 1'b1;
    mErrStatus = 8'h1F;
    grabGrant(300);
    finishTx(1);
`else
    pulses = 0;
    repeat (150) begin
      @(negedge masterClock);
      if (transmit === 1'b1) pulses++;
    end
    checkOutput("no_timeout_response", pulses, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sandbox_router.md
# sandbox_router

Multi-channel host-command router between the wide UART I/O block and up to 16 sandbox DUT processes. It decodes a channel index from the received control byte and dispatches the command word to that channel. It arbitrates round-robin among channel transmit requests and sequences each response into the UART transmitter. It replaces the single-process direct wiring in the sandbox top so that several DUTs can be exercised from one host link.

## Interface
- NUM_CH, 4: number of DUT channels, 1..16.
- WIDTH, 4: data word width in bytes; data buses are WIDTH*8 bits.
- TIMEOUT_CYCLES, 12000000: response watchdog limit in masterClock cycles (1 s at 12 MHz). Used only with the watchdog macro.

Ports:
- masterClock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- dataReceived  in  1  UART has a received word; level, held until cleared.
- control  in  8  received control byte: [7:4] channel index, [3:0] opcode.
- inputData  in  WIDTH*8  received data word.
- transmitting  in  1  UART transmitter busy.
- clearDR  out  1  one-cycle pulse that clears dataReceived.
- transmit  out  1  one-cycle pulse that starts a UART transmission.
- status  out  8  response status byte: [7:4] channel, [3:0] code.
- outputData  out  WIDTH*8  response data word.
- chValid  out  NUM_CH  one-hot, one-cycle command strobe.
- chControl  out  4  opcode broadcast to all channels.
- chData  out  WIDTH*8  command data broadcast to all channels.
- chTxReq  in  NUM_CH  per-channel response request; level.
- chStatus  in  NUM_CH*4  per-channel status codes; channel i occupies [4i+3:4i].
- chTxData  in  NUM_CH*WIDTH*8  per-channel response words.
- chTxAck  out  NUM_CH  one-hot, one-cycle grant acknowledge.

## Operation
Reset value of every output is 0. While reset is low, both FSMs are held in their IDLE states and the arbiter pointer is 0.

RX FSM (RX_IDLE, RX_WAIT):
- RX_IDLE, dataReceived=1 at cycle 0: latch control and inputData into chControl and chData.
- Cycle 1: clearDR=1. If idx < NUM_CH, chValid[idx]=1; otherwise set errPending with code 4'hE. Go to RX_WAIT.
- RX_WAIT: return to RX_IDLE once dataReceived=0, so a single word is never dispatched twice.
- chControl and chData hold their values until the next command.

TX FSM (TX_IDLE, TX_START, TX_BUSY):
- TX_IDLE, transmitting=0, any request at cycle 0. Priority order: errPending first, then channels round-robin starting at ptr.
- Cycle 1, channel grant g: status={g,chStatus[g]}, outputData=chTxData[g], chTxAck[g]=1, transmit=1. Pointer becomes g+1, wrapping from NUM_CH-1 to 0.
- Cycle 1, error grant: status={idx,code}, outputData=0, errPending cleared, pointer unchanged.
- TX_START waits for transmitting=1; TX_BUSY waits for transmitting=0, then returns to TX_IDLE.
- status and outputData hold until the next grant.

Channel rules:
- A channel must deassert chTxReq in the cycle after chTxAck; otherwise it is granted again.
- A new command may be dispatched to a channel while a response from that channel is in flight.

Simultaneous events:
- RX and TX FSMs run independently, so dispatch and grant may occur in the same cycle.
- If a second error arrives while errPending is set, the newer error overwrites the older one (single-entry error slot).

## Timing
- Command latency: dataReceived to chValid/clearDR is 1 cycle.
- Response latency: request seen in TX_IDLE to transmit is 1 cycle.
- Worst-case wait for a request is NUM_CH-1 full UART transmissions, plus one more if an error is pending.

## Configuration
- SANDBOX_ROUTER_WATCHDOG_EN defined:
  - A tracker records the last validly dispatched channel and counts cycles from its chValid.
  - The count is cleared when that channel receives chTxAck.
  - A new dispatch restarts the tracker for the new channel.
  - Reaching TIMEOUT_CYCLES-1 sets errPending with code 4'hF for that channel and stops the tracker.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- Undefined: no counter, and no 4'hF responses are ever generated.

## Structure
- Shared package sandbox_pkg holds the RX and TX state encodings, error codes ERR_BAD_CH=4'hE and ERR_TIMEOUT=4'hF, and the control-byte field positions.
- One sub-module, sandbox_rr_arbiter: NUM_CH request vector plus pointer in, one-hot grant and valid out; combinational search, with the pointer register kept in the router.

## Test plan
- Reset low mid-transmission → all outputs 0 immediately; after release, the next request is granted from channel 0.
- control=8'h23, inputData=32'hDEADBEEF → one cycle later chValid=4'b0100, chControl=3, chData=32'hDEADBEEF, clearDR pulses once; dataReceived held 5 cycles → no second chValid.
- chTxReq=4'b1111 held, each released after its ack → grants in order 0,1,2,3; the next request on channel 1 alone is granted with the pointer at 0.
- control=8'h73 with NUM_CH=4 → no chValid; response status=8'h7E, outputData=0.
- Error pending and chTxReq[2] in the same cycle → error transmitted first, then channel 2 with status={4'h2,chStatus[2]}.
- Watchdog enabled, TIMEOUT_CYCLES=100, dispatch to channel 1 with no response → status=8'h1F after 100 cycles; with the macro undefined → no response ever.
